axi2fast: RTL
=============

Name: axi2fast

Overview:
- Receive-side counterpart of the FAST-to-AXI path.
- Accepts AXI4-Stream packets (from DMA MM2S or a MAC RX path) and converts them into the 134-bit FAST pktin word format consumed by the UM.
- Generates the FAST head/body/tail tags, the invalid-byte count and the end-of-packet valid strobe.
- Enforces packet-granular backpressure and truncates oversize packets.

Parameters:
MAX_BEATS, 128, maximum 16-byte beats per packet (2048 B); longer packets are truncated and marked bad.
CNT_W, 32, width of statistics counters.

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
s_axis_tvalid  in  1  AXI-S beat valid
s_axis_tdata  in  128  AXI-S data; byte i = tdata[8i+7:8i]
s_axis_tkeep  in  16  byte enables; contiguous from bit 0
s_axis_tlast  in  1  last beat of packet
s_axis_tready  out  1  beat accepted when tvalid&tready
pktin_data_wr  out  1  FAST word write strobe
pktin_data  out  134  FAST word: [133:132] tag, [131:128] invalid bytes, [127:0] data
pktin_valid_wr  out  1  end-of-packet status strobe
pktin_valid  out  1  1 = good packet, 0 = truncated
pktin_ready  in  1  UM has room for one MAX_BEATS packet
stat_pkt_cnt  out  CNT_W  good packets forwarded
stat_drop_cnt  out  CNT_W  runt (single-beat) packets dropped
stat_trunc_cnt  out  CNT_W  truncated packets

Behaviour:
- Reset (aresetn=0, asynchronous): state=IDLE; s_axis_tready=0, pktin_data_wr=0, pktin_data=0, pktin_valid_wr=0, pktin_valid=0, beat counter=0, counters=0. A packet in flight is abandoned. After reset the block resynchronises by treating the next accepted beat as a packet start.
- Outputs are registered. Latency is 1 cycle from accepted beat to pktin_data_wr.
- Tags:
  - 2'b01 on the first beat.
  - 2'b11 on middle beats.
  - 2'b10 on the last beat.
- [131:128]:
  - 0 on non-last beats.
  - 16 - popcount(tkeep) on the last beat; tkeep=16'hFFFF gives 0.
  - tkeep=0 on a last beat is treated as 16'hFFFF.
- Byte order: AXI byte i maps to pktin_data[127-8i -: 8]. AXI byte 0 is the first on-wire byte and lands in the MSB byte.
- pktin_valid_wr pulses together with the tail-word pktin_data_wr.
- States:
  - IDLE:
    - s_axis_tready = pktin_ready.
    - On an accepted beat with tlast=1 (runt): drop the beat, no writes, stat_drop_cnt++, stay in IDLE.
    - On an accepted beat with tlast=0: emit a head word, beat counter=1, go to BODY.
  - BODY:
    - s_axis_tready=1. pktin_ready is ignored mid-packet; FAST writes have no backpressure.
    - tvalid gaps produce no writes.
    - Each accepted beat increments the beat counter.
    - Beat with tlast=1 and counter+1 ≤ MAX_BEATS: emit tail, pktin_valid=1, stat_pkt_cnt++, go to IDLE.
    - Beat where counter+1 == MAX_BEATS with tlast=0: emit it tagged 2'b10 with [131:128]=0, pktin_valid=0, stat_trunc_cnt++, go to DISCARD.
  - DISCARD: s_axis_tready=1. Accept and drop beats until tlast, then go to IDLE. No writes.
- pktin_ready is sampled only in IDLE. Deassertion mid-packet does not stall the packet.
- Counters saturate at all-ones; they do not wrap.

Optional Feature:
- Macro: AXI2FAST_STATS_EN.
- Defined: the three stat counters are implemented as described.
- Undefined: no counter flops are built and the stat_* outputs are tied to 0. All datapath behaviour is identical either way.

Test Plan:
- 4-beat packet, bytes 0x00..0x3F, last tkeep=16'h00FF, pktin_ready=1 -> 4 writes tagged 01,11,11,10. Tail [131:128]=4'd8. pktin_data[127:120] of beat 0 = 0x00. pktin_valid_wr with pktin_valid=1 on the 4th write. stat_pkt_cnt=1.
- Single-beat packet (tlast on first beat) -> no pktin_data_wr and no pktin_valid_wr; stat_drop_cnt=1; tready stays high.
- pktin_ready=0 in IDLE with tvalid=1 -> tready=0 and no beats consumed. Raise pktin_ready, then drop it after the head beat -> the remaining 3 beats are still accepted and written back-to-back.
- MAX_BEATS=8, 10-beat packet -> 8 writes, 8th tagged 10 with pktin_valid=0. Beats 9-10 accepted and dropped. stat_trunc_cnt=1. A following 2-beat packet is forwarded normally.
- tvalid gaps of 3 cycles between beats of a 3-beat packet -> exactly 3 writes, tags intact, no spurious strobes.
- aresetn pulsed low after beat 2 of a 5-beat packet -> all outputs 0 immediately. The next packet starts with a head tag; the remaining old beats presented after reset are treated as a new packet.

Source files
------------

// File: rtl/axi2fast_if.sv
// axi2fast_if: AXI4-Stream input, FAST pktin output and statistics of the axi2fast bridge
interface axi2fast_if #(parameter int CNT_W = 32);
  logic             s_axis_tvalid;
  logic [127:0]     s_axis_tdata;
  logic [15:0]      s_axis_tkeep;
  logic             s_axis_tlast;
  logic             s_axis_tready;
  logic             pktin_data_wr;
  logic [133:0]     pktin_data;
  logic             pktin_valid_wr;
  logic             pktin_valid;
  logic             pktin_ready;
  logic [CNT_W-1:0] stat_pkt_cnt;
  logic [CNT_W-1:0] stat_drop_cnt;
  logic [CNT_W-1:0] stat_trunc_cnt;
  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, pktin_ready,
    output s_axis_tready, pktin_data_wr, pktin_data, pktin_valid_wr, pktin_valid,
           stat_pkt_cnt, stat_drop_cnt, stat_trunc_cnt
  );
  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, pktin_ready,
    input  s_axis_tready, pktin_data_wr, pktin_data, pktin_valid_wr, pktin_valid,
           stat_pkt_cnt, stat_drop_cnt, stat_trunc_cnt
  );
endinterface

// File: rtl/axi2fast.sv
// axi2fast: AXI4-Stream packets to 134-bit FAST pktin words with truncation of oversize packets.
// Statistics counters are built only when AXI2FAST_STATS_EN is defined.
module axi2fast #(
  parameter int MAX_BEATS = 128,
  parameter int CNT_W     = 32
) (
  input logic       aclk,
  input logic       aresetn,
  axi2fast_if.slave bus
);
  localparam int BW = $clog2(MAX_BEATS + 1);
  typedef enum logic [1:0] {IDLE, BODY, DISCARD} state_t;
  state_t         state_q;
  logic           run_q, data_wr_q, valid_wr_q, valid_q, acc;
  logic [133:0]   data_q;
  logic [BW-1:0]  beat_q, beat_d;
  logic [127:0]   swap;
  logic [3:0]     inv;
`ifdef AXI2FAST_STATS_EN
  logic [CNT_W-1:0] pkt_q, drop_q, trunc_q;
  assign bus.stat_pkt_cnt   = pkt_q;
  assign bus.stat_drop_cnt  = drop_q;
  assign bus.stat_trunc_cnt = trunc_q;
`else
  assign bus.stat_pkt_cnt   = CNT_W'(0);
  assign bus.stat_drop_cnt  = CNT_W'(0);
  assign bus.stat_trunc_cnt = CNT_W'(0);
`endif
  // run_q holds tready low while reset is asserted and on the first cycle after it
  assign bus.s_axis_tready  = run_q & ((state_q != IDLE) | bus.pktin_ready);
  assign bus.pktin_data_wr  = data_wr_q;
  assign bus.pktin_data     = data_q;
  assign bus.pktin_valid_wr = valid_wr_q;
  assign bus.pktin_valid    = valid_q;
  always_comb begin
    acc    = bus.s_axis_tvalid & bus.s_axis_tready;
    beat_d = beat_q + 1'b1;
    // tkeep=0 gives 16-0, which wraps to 0 exactly like a full beat
    inv    = 4'(5'd16 - 5'($countones(bus.s_axis_tkeep)));
    swap   = '0;
    for (int i = 0; i < 16; i++) swap[127-8*i -: 8] = bus.s_axis_tdata[8*i +: 8];
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      run_q      <= 1'b0;
      data_wr_q  <= 1'b0;
      data_q     <= '0;
      valid_wr_q <= 1'b0;
      valid_q    <= 1'b0;
      beat_q     <= '0;
`ifdef AXI2FAST_STATS_EN
      pkt_q      <= '0;
      drop_q     <= '0;
      trunc_q    <= '0;
`endif
    end else begin
      run_q      <= 1'b1;
      data_wr_q  <= 1'b0;
      valid_wr_q <= 1'b0;
      if (acc) begin
        case (state_q)
          IDLE: begin
            if (bus.s_axis_tlast) begin
`ifdef AXI2FAST_STATS_EN
              drop_q <= drop_q + CNT_W'(drop_q != '1);
`endif
            end else begin
              data_wr_q <= 1'b1;
              data_q    <= {2'b01, 4'd0, swap};
              beat_q    <= BW'(1);
              state_q   <= BODY;
            end
          end
          BODY: begin
            data_wr_q <= 1'b1;
            beat_q    <= beat_d;
            if (bus.s_axis_tlast) begin
              data_q     <= {2'b10, inv, swap};
              valid_wr_q <= 1'b1;
              valid_q    <= 1'b1;
              state_q    <= IDLE;
`ifdef AXI2FAST_STATS_EN
              pkt_q      <= pkt_q + CNT_W'(pkt_q != '1);
`endif
            end else if (beat_d == BW'(MAX_BEATS)) begin
              data_q     <= {2'b10, 4'd0, swap};
              valid_wr_q <= 1'b1;
              valid_q    <= 1'b0;
              state_q    <= DISCARD;
`ifdef AXI2FAST_STATS_EN
              trunc_q    <= trunc_q + CNT_W'(trunc_q != '1);
`endif
            end else begin
              data_q     <= {2'b11, 4'd0, swap};
            end
          end
          DISCARD: state_q <= bus.s_axis_tlast ? IDLE : DISCARD;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule
